// File: rtl/fpu_result_queue.sv
// fpu_result_queue: FIFO buffer for FPU results headed to core writeback,
// plus the sticky fflags CSR and a retired-exception interrupt pulse.
// Head-entry fields drive out_* directly from storage, so a push is
// visible to the consumer one cycle after it is accepted.
module fpu_result_queue #(
    parameter  int STD   = 15,
    parameter  int INT_W = 32,
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_is_int,
    input  logic [STD:0]     in_fp,
    input  logic [INT_W-1:0] in_int,
    input  logic [4:0]       in_flags,
    input  logic             in_exc,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_is_int,
    output logic [STD:0]     out_fp,
    output logic [INT_W-1:0] out_int,

    input  logic             flush,
    input  logic             csr_wr,
    input  logic [4:0]       csr_wdata,
    output logic [4:0]       fflags,
    output logic [CNT_W-1:0] count,
    output logic             irq
);

    localparam logic [4:0] FLAG_NV = 5'b10000;

    // Entry storage; data is never reset, validity is tracked by count_q.
    logic [TAG_W-1:0] tag_mem_q    [DEPTH];
    logic             is_int_mem_q [DEPTH];
    logic [STD:0]     fp_mem_q     [DEPTH];
    logic [INT_W-1:0] int_mem_q    [DEPTH];
    logic [4:0]       flags_mem_q  [DEPTH];
    logic             exc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             irq_q,    irq_d;

    logic             push;
    logic             pop;
    logic [4:0]       head_flags;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign out_tag    = tag_mem_q[rd_ptr_q];
    assign out_is_int = is_int_mem_q[rd_ptr_q];
    assign out_fp     = fp_mem_q[rd_ptr_q];
    assign out_int    = int_mem_q[rd_ptr_q];

    // A retired exception always contributes NV on top of the op's own flags.
    assign head_flags = flags_mem_q[rd_ptr_q] | (exc_mem_q[rd_ptr_q] ? FLAG_NV : 5'b00000);

    assign fflags = fflags_q;
    assign count  = count_q;
    assign irq    = irq_q;

    // Write the incoming result into the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q]    <= in_tag;
            is_int_mem_q[wr_ptr_q] <= in_is_int;
            fp_mem_q[wr_ptr_q]     <= in_fp;
            int_mem_q[wr_ptr_q]    <= in_int;
            flags_mem_q[wr_ptr_q]  <= in_flags;
            exc_mem_q[wr_ptr_q]    <= in_exc;
        end
    end

    // Next-state for pointers, occupancy, sticky flags and interrupt pulse.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fflags_d = fflags_q;
        irq_d    = pop & exc_mem_q[rd_ptr_q];

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A concurrent CSR write never hides flags from an entry retiring now.
        if (csr_wr && pop) begin
            fflags_d = csr_wdata | head_flags;
        end else if (csr_wr) begin
            fflags_d = csr_wdata;
        end else if (pop) begin
            fflags_d = fflags_q | head_flags;
        end
    end

    // Control state register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            irq_q    <= irq_d;
        end
    end

endmodule
